// File: rtl/coherent_mem_arbiter_if.sv
// Bus bundle between N L1 cache pairs, the arbiter and a single RAM port.
// Modports: master = caches + RAM side, slave = arbiter.
interface coherent_mem_arbiter_if #(
  parameter int CPUS = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [CPUS-1:0]    iREN;
  logic [CPUS*AW-1:0] iaddr;
  logic [CPUS-1:0]    dREN;
  logic [CPUS-1:0]    dWEN;
  logic [CPUS*AW-1:0] daddr;
  logic [CPUS*DW-1:0] dstore;
  logic [CPUS-1:0]    cctrans;
  logic [CPUS-1:0]    ccwrite;
  logic [CPUS-1:0]    iwait;
  logic [CPUS-1:0]    dwait;
  logic [CPUS*DW-1:0] iload;
  logic [CPUS*DW-1:0] dload;
  logic [CPUS-1:0]    ccwait;
  logic [CPUS-1:0]    ccinv;
  logic [CPUS*AW-1:0] ccsnoopaddr;
  logic               ramREN;
  logic               ramWEN;
  logic [AW-1:0]      ramaddr;
  logic [DW-1:0]      ramstore;
  logic [DW-1:0]      ramload;
  logic [1:0]         ramstate;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    output cctrans, ccwrite, ramload, ramstate,
    input  iwait, dwait, iload, dload,
    input  ccwait, ccinv, ccsnoopaddr,
    input  ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  cctrans, ccwrite, ramload, ramstate,
    output iwait, dwait, iload, dload,
    output ccwait, ccinv, ccsnoopaddr,
    output ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherent_mem_arbiter.sv
// N-core coherence arbiter: round-robin I/D grant, snoop, c2c xfer, RAM.
// Ports: CLK, nRST (async, active-low), bus (slave side of the bundle).
module coherent_mem_arbiter #(
  parameter int CPUS      = 4,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int SNOOP_LAT = 2
) (
  input logic                  CLK,
  input logic                  nRST,
  coherent_mem_arbiter_if.slave bus
);
  localparam int GW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic [2:0] {
    IDLE, SNOOP, RESP, XFER, RAMD, RAMI
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   g_q, g_d;
  logic [GW-1:0]   s_q, s_d;
  logic [GW-1:0]   dptr_q, dptr_d;
  logic [GW-1:0]   iptr_q, iptr_d;
  logic [2:0]      wcnt_q, wcnt_d;

  logic [CPUS-1:0] dreq;
  logic            dhit, ihit, shit, acc;
  logic [GW-1:0]   dsel, isel, ssel;
  int              di, ii, sj;

  assign dreq = bus.dREN | bus.dWEN;
  assign acc  = (bus.ramstate == 2'b10);

  function automatic logic [GW-1:0] inc(
    input logic [GW-1:0] p
  );
    return (p == GW'(CPUS-1)) ? '0 : p + 1'b1;
  endfunction

  // Scan downwards so the nearest core
  // after the pointer wins last.
  always_comb begin
    dhit = 1'b0;
    ihit = 1'b0;
    shit = 1'b0;
    dsel = '0;
    isel = '0;
    ssel = '0;
    di   = 0;
    ii   = 0;
    sj   = 0;
    for (int k = CPUS-1; k >= 0; k--) begin
      di = (int'(dptr_q) + k) % CPUS;
      ii = (int'(iptr_q) + k) % CPUS;
      if (dreq[di]) begin
        dhit = 1'b1;
        dsel = GW'(di);
      end
      if (bus.iREN[ii]) begin
        ihit = 1'b1;
        isel = GW'(ii);
      end
    end
    for (int k = CPUS-1; k >= 1; k--) begin
      sj = (int'(g_q) + k) % CPUS;
      if (bus.dWEN[sj]) begin
        shit = 1'b1;
        ssel = GW'(sj);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      g_q     <= '0;
      s_q     <= '0;
      dptr_q  <= '0;
      iptr_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      s_q     <= s_d;
      dptr_q  <= dptr_d;
      iptr_q  <= iptr_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    s_d     = s_q;
    dptr_d  = dptr_q;
    iptr_d  = iptr_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        if (dhit) begin
          g_d     = dsel;
          state_d = bus.cctrans[dsel] ? SNOOP : RAMD;
        end else if (ihit) begin
          g_d     = isel;
          state_d = RAMI;
        end
      end
      SNOOP: begin
        if (!dreq[g_q]) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
          wcnt_d  = '0;
        end
      end
      RESP: begin
        if (!dreq[g_q]) begin
          state_d = IDLE;
        end else if (shit) begin
          s_d     = ssel;
          state_d = XFER;
        end else if (wcnt_q == 3'(SNOOP_LAT-1)) begin
          state_d = RAMD;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      XFER: begin
        if (!bus.dWEN[s_q]) begin
          if (dreq[g_q]) begin
            state_d = RAMD;
          end else begin
            state_d = IDLE;
            dptr_d  = inc(g_q);
          end
        end
      end
      RAMD: begin
        if (!dreq[g_q]) begin
          state_d = IDLE;
          dptr_d  = inc(g_q);
        end
      end
      RAMI: begin
        if (!bus.iREN[g_q]) begin
          state_d = IDLE;
          iptr_d  = inc(g_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.iwait       = '1;
    bus.dwait       = '1;
    bus.iload       = '0;
    bus.dload       = '0;
    bus.ccwait      = '0;
    bus.ccinv       = '0;
    bus.ccsnoopaddr = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;
    if (nRST) begin
      if (state_q == SNOOP || state_q == RESP ||
          state_q == XFER) begin
        for (int j = 0; j < CPUS; j++) begin
          if (GW'(j) != g_q) begin
            bus.ccwait[j] = 1'b1;
            bus.ccinv[j]  = bus.ccwrite[g_q];
            bus.ccsnoopaddr[j*AW +: AW] =
              bus.daddr[g_q*AW +: AW];
          end
        end
      end
      unique case (state_q)
        XFER: begin
          bus.ramWEN   = 1'b1;
          bus.ramaddr  = bus.daddr[s_q*AW +: AW];
          bus.ramstore = bus.dstore[s_q*DW +: DW];
          if (bus.dREN[g_q])
            bus.dload[g_q*DW +: DW] =
              bus.dstore[s_q*DW +: DW];
          if (acc) begin
            bus.dwait[s_q] = 1'b0;
            bus.dwait[g_q] = ~bus.dREN[g_q];
          end
        end
        RAMD: begin
          bus.ramaddr  = bus.daddr[g_q*AW +: AW];
          bus.ramREN   = bus.dREN[g_q];
          bus.ramWEN   = bus.dWEN[g_q] & ~bus.dREN[g_q];
          bus.ramstore = bus.dstore[g_q*DW +: DW];
          bus.dload[g_q*DW +: DW] = bus.ramload;
          bus.dwait[g_q] = ~acc;
        end
        RAMI: begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr[g_q*AW +: AW];
          bus.iload[g_q*DW +: DW] = bus.ramload;
          bus.iwait[g_q] = ~acc;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_coherent_mem_arbiter.sv
// Scoreboard bench for coherent_mem_arbiter (CPUS=4).
// Directed requests; monitor checks every deasserted wait.
module tb_coherent_mem_arbiter;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic rcnt = 1'b0;

  coherent_mem_arbiter_if #(.CPUS(4), .AW(32), .DW(32)) bus();

  coherent_mem_arbiter #(
    .CPUS(4), .AW(32), .DW(32), .SNOOP_LAT(2)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // RAM: one BUSY cycle, then ACCESS, per request
  always @(posedge CLK)
    rcnt <= (bus.ramREN | bus.ramWEN) ? ~rcnt : 1'b0;
  assign bus.ramstate = (bus.ramREN | bus.ramWEN) ?
                        (rcnt ? 2'b10 : 2'b01) : 2'b00;
  assign bus.ramload  = bus.ramaddr + 32'h1000_0000;

  typedef struct packed {
    logic        isI;
    logic [1:0]  core;
    logic [31:0] load;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] ipend = '0;
  int irearm = 0;

  function automatic exp_t mk(bit i, int c, logic [31:0] ld,
                              bit r, bit w, logic [31:0] a,
                              logic [31:0] s);
    exp_t e;
    e.isI = i; e.core = 2'(c); e.load = ld;
    e.ren = r; e.wen = w; e.addr = a; e.store = s;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mon(input bit isI, input int c);
    exp_t a, e;
    a.isI   = isI;
    a.core  = 2'(c);
    a.load  = isI ? bus.iload[c*32 +: 32] : bus.dload[c*32 +: 32];
    a.ren   = bus.ramREN;
    a.wen   = bus.ramWEN;
    a.addr  = bus.ramaddr;
    a.store = bus.ramstore;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got %s core %0d with empty queue",
               isI ? "I" : "D", c);
    end else begin
      e = q.pop_front();
      if (a !== e) begin
        n_fail++;
        $display("FAIL sb_%s%0d: got %h want %h",
                 isI ? "I" : "D", c, a, e);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (nRST) begin
      for (int i = 0; i < 4; i++)
        if (!bus.dwait[i]) mon(1'b0, i);
      for (int i = 0; i < 4; i++)
        if (!bus.iwait[i]) mon(1'b1, i);
    end
  end

  // One cycle; a served core drops its request.
  task automatic step();
    @(negedge CLK);
    #1;
    bus.iREN = bus.iREN | ipend;
    ipend = '0;
    for (int i = 0; i < 4; i++) begin
      if (!bus.dwait[i]) begin
        bus.dREN[i] = 1'b0;
        bus.dWEN[i] = 1'b0;
      end
      if (!bus.iwait[i] && bus.iREN[i]) begin
        bus.iREN[i] = 1'b0;
        if (irearm > 0) begin
          ipend[i] = 1'b1;
          irearm--;
        end
      end
    end
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((((bus.dREN | bus.dWEN | bus.iREN | ipend) != 0) ||
            q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    chk({nm, "_timeout"}, 128'(n < 300), 128'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iREN = '0; bus.iaddr = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.daddr = '0; bus.dstore = '0;
    bus.cctrans = '0; bus.ccwrite = '0;

    // reset with a request pending
    bus.dREN = 4'b0001;
    bus.daddr[31:0] = 32'h100;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_dwait", 128'(bus.dwait), 128'hF);
    chk("rst_iwait", 128'(bus.iwait), 128'hF);
    chk("rst_ram", {bus.ramREN, bus.ramWEN, bus.ramaddr}, 128'h0);
    chk("rst_cc", {bus.ccwait, bus.ccinv}, 128'h0);
    bus.dREN = '0;
    nRST = 1'b1;
    step();
    chk("idle_waits", {bus.dwait, bus.iwait}, 128'hFF);
    chk("idle_ram", {bus.ramREN, bus.ramWEN}, 128'h0);

    // instruction rotation 0,1,2,3,0
    for (int i = 0; i < 4; i++)
      bus.iaddr[i*32 +: 32] = 32'h1000 + 32'(i * 16);
    q.push_back(mk(1, 0, 32'h1000_1000, 1, 0, 32'h1000, 0));
    q.push_back(mk(1, 1, 32'h1000_1010, 1, 0, 32'h1010, 0));
    q.push_back(mk(1, 2, 32'h1000_1020, 1, 0, 32'h1020, 0));
    q.push_back(mk(1, 3, 32'h1000_1030, 1, 0, 32'h1030, 0));
    q.push_back(mk(1, 0, 32'h1000_1000, 1, 0, 32'h1000, 0));
    irearm = 1;
    bus.iREN = 4'hF;
    wait_done("irot");

    // cores 0 and 2 read, 0 first
    bus.daddr[0*32 +: 32] = 32'h100;
    bus.daddr[2*32 +: 32] = 32'h200;
    q.push_back(mk(0, 0, 32'h1000_0100, 1, 0, 32'h100, 0));
    q.push_back(mk(0, 2, 32'h1000_0200, 1, 0, 32'h200, 0));
    bus.dREN = 4'b0101;
    wait_done("drr");

    // dptr now 3: core 3 before core 0, then wrap
    bus.daddr[3*32 +: 32] = 32'h300;
    bus.daddr[0*32 +: 32] = 32'h104;
    q.push_back(mk(0, 3, 32'h1000_0300, 1, 0, 32'h300, 0));
    q.push_back(mk(0, 0, 32'h1000_0104, 1, 0, 32'h104, 0));
    bus.dREN = 4'b1001;
    wait_done("dwrap");

    // snoop hit: core 3 supplies core 1
    bus.daddr[1*32 +: 32] = 32'h40;
    bus.daddr[3*32 +: 32] = 32'h40;
    bus.dstore[3*32 +: 32] = 32'hDEAD_BEEF;
    q.push_back(mk(0, 1, 32'hDEAD_BEEF, 0, 1, 32'h40, 32'hDEAD_BEEF));
    q.push_back(mk(0, 3, 32'h0, 0, 1, 32'h40, 32'hDEAD_BEEF));
    bus.cctrans[1] = 1'b1;
    bus.dREN[1] = 1'b1;
    step();
    chk("hit_ccwait", 128'(bus.ccwait), 128'hD);
    chk("hit_snaddr", bus.ccsnoopaddr,
        {32'h40, 32'h40, 32'h0, 32'h40});
    chk("hit_ccinv", 128'(bus.ccinv), 128'h0);
    step();
    chk("hit_resp_ccwait", 128'(bus.ccwait), 128'hD);
    bus.dWEN[3] = 1'b1;
    wait_done("hit");
    bus.cctrans = '0;

    // snoop miss, exclusive write by core 0
    bus.daddr[0*32 +: 32] = 32'h80;
    bus.dstore[0*32 +: 32] = 32'h1234_5678;
    q.push_back(mk(0, 0, 32'h1000_0080, 0, 1, 32'h80, 32'h1234_5678));
    bus.cctrans[0] = 1'b1;
    bus.ccwrite[0] = 1'b1;
    bus.dWEN[0] = 1'b1;
    step();
    chk("miss_snoop_inv", {bus.ccwait, bus.ccinv}, 128'hEE);
    step();
    chk("miss_resp0_inv", {bus.ccwait, bus.ccinv}, 128'hEE);
    step();
    chk("miss_resp1_inv", {bus.ccwait, bus.ccinv}, 128'hEE);
    step();
    chk("miss_ramd_inv", {bus.ccwait, bus.ccinv}, 128'h00);
    wait_done("miss");
    bus.cctrans = '0;
    bus.ccwrite = '0;

    // data beats instruction in the same cycle
    bus.iaddr[2*32 +: 32] = 32'h300;
    bus.daddr[1*32 +: 32] = 32'h44;
    bus.dstore[0*32 +: 32] = '0;
    q.push_back(mk(0, 1, 32'h1000_0044, 1, 0, 32'h44, 0));
    q.push_back(mk(1, 2, 32'h1000_0300, 1, 0, 32'h300, 0));
    bus.iREN[2] = 1'b1;
    bus.dREN[1] = 1'b1;
    step();
    chk("dfirst_iwait", 128'(bus.iwait), 128'hF);
    wait_done("dfirst");

    // reset during XFER, then re-arbitration
    bus.daddr[2*32 +: 32] = 32'h60;
    bus.cctrans[2] = 1'b1;
    bus.dREN[2] = 1'b1;
    step();
    step();
    bus.daddr[0*32 +: 32] = 32'h60;
    bus.dstore[0*32 +: 32] = 32'hCAFE_F00D;
    bus.dWEN[0] = 1'b1;
    step();
    chk("xfer_ram", {bus.ramWEN, bus.ramaddr, bus.ramstore},
        {1'b1, 32'h60, 32'hCAFE_F00D});
    nRST = 1'b0;
    #1;
    chk("mrst_waits", {bus.dwait, bus.iwait}, 128'hFF);
    chk("mrst_ram", {bus.ramREN, bus.ramWEN, bus.ramaddr,
                     bus.ramstore}, 128'h0);
    chk("mrst_cc", 128'(bus.ccwait), 128'h0);
    bus.dWEN[0] = 1'b0;
    step();
    chk("mrst_hold", {bus.dwait, bus.ccwait}, 128'hF0);
    q.push_back(mk(0, 2, 32'h1000_0060, 1, 0, 32'h60, 0));
    nRST = 1'b1;
    step();
    chk("rearb_ccwait", 128'(bus.ccwait), 128'hB);
    wait_done("rearb");
    chk("sb_empty", 128'(q.size()), 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
